multi_btn_debounce: RTL and testbench

MULTI_BTN_DEBOUNCE -- requirements
Module: multi_btn_debounce

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 114 +++++++++++
 rtl/multi_btn_debounce.sv | 34 +++
 tb/tb_multi_btn_debounce.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer.
// State encodings and counter sizing helper.
package debounce_pkg;

    // Bit 1 of the encoding is the debounced level.
    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b11,
        WAIT_LO = 2'b10
    } state_e;

    // Bits needed to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchronizer, stability FSM,
// run-length counter and registered edge/toggle outputs.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   toggle_q, toggle_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    // Register FSM state, counter and output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
        end
    end

    // Next state: a level is accepted only after an unbroken run.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        toggle_d = toggle_q;
        unique case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = IDLE_HI;
                    cnt_d    = '0;
                    rise_d   = 1'b1;
                    toggle_d = ~toggle_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o  = state_q[1];
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign toggle_o = toggle_q;

endmodule

// File: rtl/multi_btn_debounce.sv
// N_CH independent debounced buttons.
// Pure replication of debounce_channel.
module multi_btn_debounce
    import debounce_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = 1000000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_toggle
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .btn_i   (btn_in[i]),
            .level_o (btn_level[i]),
            .rise_o  (btn_rise[i]),
            .fall_o  (btn_fall[i]),
            .toggle_o(btn_toggle[i])
        );
    end

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Directed bench for multi_btn_debounce.
// STABLE_CYCLES=4, SYNC_STAGES=2 -> 7-edge latency.
module tb_multi_btn_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_rise;
    logic [3:0] btn_fall;
    logic [3:0] btn_toggle;

    int vectors = 0;
    int errs    = 0;

    logic [3:0] seen_rise;
    logic [3:0] seen_fall;
    logic [3:0] seen_lvl;

    always #5 clk = ~clk;

    multi_btn_debounce #(
        .N_CH         (4),
        .STABLE_CYCLES(4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_toggle(btn_toggle)
    );

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            seen_rise = seen_rise | btn_rise;
            seen_fall = seen_fall | btn_fall;
            seen_lvl  = seen_lvl | btn_level;
        end
    endtask

    task automatic clr_seen();
        seen_rise = '0;
        seen_fall = '0;
        seen_lvl  = '0;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 4'b0000;
        clr_seen();
        run(2);
        chk("rst_level", btn_level, 4'b0000);
        chk("rst_rise", btn_rise, 4'b0000);
        chk("rst_fall", btn_fall, 4'b0000);
        chk("rst_toggle", btn_toggle, 4'b0000);
        reset = 1'b0;
        run(2);

        // Clean press on ch0
        btn_in = 4'b0001;
        run(6);
        chk("a_lvl_e6", btn_level, 4'b0000);
        chk("a_rise_e6", btn_rise, 4'b0000);
        run(1);
        chk("a_lvl_e7", btn_level, 4'b0001);
        chk("a_rise_e7", btn_rise, 4'b0001);
        chk("a_tog_e7", btn_toggle, 4'b0001);
        run(1);
        chk("a_rise_e8", btn_rise, 4'b0000);
        chk("a_lvl_e8", btn_level, 4'b0001);
        run(12);
        btn_in = 4'b0000;
        run(6);
        chk("a_rel_lvl_e6", btn_level, 4'b0001);
        chk("a_rel_fall_e6", btn_fall, 4'b0000);
        run(1);
        chk("a_rel_lvl_e7", btn_level, 4'b0000);
        chk("a_rel_fall_e7", btn_fall, 4'b0001);
        chk("a_rel_tog", btn_toggle, 4'b0001);
        run(1);
        chk("a_rel_fall_e8", btn_fall, 4'b0000);
        run(2);

        // Bounce on ch1
        clr_seen();
        btn_in = 4'b0010;
        run(3);
        btn_in = 4'b0000;
        run(1);
        btn_in = 4'b0010;
        run(3);
        btn_in = 4'b0000;
        run(10);
        chk("b_ch1", {seen_lvl[1], seen_rise[1], seen_fall[1],
                      btn_toggle[1]}, 4'b0000);
        chk("b_rise_any", seen_rise, 4'b0000);
        chk("b_lvl_any", seen_lvl, 4'b0000);

        // Press / release / press on ch2
        clr_seen();
        btn_in = 4'b0100;
        run(7);
        chk("c_rise1", btn_rise, 4'b0100);
        chk("c_lvl1", btn_level, 4'b0100);
        run(3);
        btn_in = 4'b0000;
        run(6);
        chk("c_lvl_hold", btn_level, 4'b0100);
        chk("c_fall_e6", btn_fall, 4'b0000);
        run(1);
        chk("c_fall_e7", btn_fall, 4'b0100);
        chk("c_lvl_rel", btn_level, 4'b0000);
        chk("c_tog1", btn_toggle, 4'b0101);
        chk("c_one_rise", seen_rise, 4'b0100);
        run(3);
        btn_in = 4'b0100;
        run(7);
        chk("c_rise2", btn_rise, 4'b0100);
        chk("c_tog2", btn_toggle, 4'b0001);
        btn_in = 4'b0000;
        run(10);
        chk("c_lvl_end", btn_level, 4'b0000);

        // Simultaneous ch0 + ch3
        btn_in = 4'b1001;
        run(6);
        chk("d_rise_e6", btn_rise, 4'b0000);
        run(1);
        chk("d_rise_e7", btn_rise, 4'b1001);
        chk("d_lvl_e7", btn_level, 4'b1001);
        chk("d_tog_e7", btn_toggle, 4'b1000);
        chk("d_fall_e7", btn_fall, 4'b0000);
        run(1);
        chk("d_rise_e8", btn_rise, 4'b0000);
        btn_in = 4'b0000;
        run(7);
        chk("d_fall_rel", btn_fall, 4'b1001);
        chk("d_rise_rel", btn_rise, 4'b0000);
        chk("d_lvl_rel", btn_level, 4'b0000);
        run(2);

        // Reset during ch0 WAIT_HI
        btn_in = 4'b0001;
        run(4);
        clr_seen();
        reset = 1'b1;
        #1;
        chk("e_rst_lvl", btn_level, 4'b0000);
        chk("e_rst_tog", btn_toggle, 4'b0000);
        run(1);
        reset = 1'b0;
        run(6);
        chk("e_lvl_e6", btn_level, 4'b0000);
        chk("e_no_rise", seen_rise, 4'b0000);
        run(1);
        chk("e_lvl_e7", btn_level, 4'b0001);
        chk("e_rise_e7", btn_rise, 4'b0001);
        chk("e_tog_e7", btn_toggle, 4'b0001);
        run(3);

        // Reset during ch0 IDLE_HI
        clr_seen();
        reset = 1'b1;
        #1;
        chk("f_rst_lvl", btn_level, 4'b0000);
        chk("f_rst_fall", btn_fall, 4'b0000);
        chk("f_rst_tog", btn_toggle, 4'b0000);
        run(1);
        reset = 1'b0;
        run(6);
        chk("f_lvl_e6", btn_level, 4'b0000);
        chk("f_no_fall", seen_fall, 4'b0000);
        chk("f_no_rise", seen_rise, 4'b0000);
        run(1);
        chk("f_lvl_e7", btn_level, 4'b0001);
        chk("f_rise_e7", btn_rise, 4'b0001);
        btn_in = 4'b0000;
        run(10);
        chk("f_lvl_end", btn_level, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
